seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/clock_disp_pkg.sv | 42 ++++
 rtl/seg7_scan_driver_if.sv | 40 ++++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_disp_pkg.sv
// -----------------------------------------------------------------------------
// clock_disp_pkg
// Shared constants and types for the 8-digit multiplexed clock display.
//   NUM_DIGITS       number of scanned digits
//   SEG_0..SEG_9     active-low glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_DASH         glyph shown for non-decimal nibbles (only g lit)
//   SEG_BLANK        all segments off
//   disp_snap_t      per-frame snapshot of every display control input
//   digit_nibble()   picks nibble idx out of the packed field0..field3 word
// -----------------------------------------------------------------------------
package clock_disp_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // fields[7:0] is field0 (digits 1:0), fields[31:24] is field3 (digits 7:6).
   typedef struct packed {
      logic [31:0] fields;
      logic [7:0]  dp_mask;
      logic [1:0]  sel_field;
      logic        set_mode;
      logic        lz_blank;
   } disp_snap_t;

   // Digit idx lives at bit offset 4*idx; concatenation avoids 3-bit overflow.
   function automatic logic [3:0] digit_nibble(logic [31:0] fields, logic [2:0] idx);
      return fields[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display data inputs and the multiplexed LED outputs.
//   field0..field3  packed BCD bytes (field0 = digits 1:0)
//   set_mode        user is editing a field
//   sel_field       field being edited
//   lz_blank        blank a leading zero in digit 7
//   dp_mask         decimal point enable per digit
//   seg_n, dp_n     active-low segment and decimal-point drive
//   an_n            active-low digit anodes
//   frame_start     one-cycle pulse at each frame snapshot
// Modports: master = data source / display consumer, slave = scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
   import clock_disp_pkg::*;

   logic [7:0]            field0;
   logic [7:0]            field1;
   logic [7:0]            field2;
   logic [7:0]            field3;
   logic                  set_mode;
   logic [1:0]            sel_field;
   logic                  lz_blank;
   logic [7:0]            dp_mask;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_n;
   logic                  frame_start;

   modport master (
      output field0, field1, field2, field3, set_mode, sel_field, lz_blank, dp_mask,
      input  seg_n, dp_n, an_n, frame_start
   );

   modport slave (
      input  field0, field1, field2, field3, set_mode, sel_field, lz_blank, dp_mask,
      output seg_n, dp_n, an_n, frame_start
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational nibble to active-low 7-segment decoder.
//   nibble  4-bit digit value; 0..9 give decimal glyphs, A..F give a dash
//   seg_n   segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_7seg
   import clock_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // NOTE: the default before the case gives every path a value, so no latch is inferred.
   always_comb begin
      seg_n = SEG_DASH;
      case (nibble)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each digit owns SCAN_DIV clocks; the first BLANK_CYC of them keep all anodes
// off to avoid ghosting. All inputs are sampled once per frame (at the 7->0
// digit wrap) so a frame never mixes old and new values. A selected field
// blinks while set_mode is high, with a half-period of BLINK_FRAMES frames.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     seg7_scan_driver_if.slave (data inputs, LED outputs, frame_start)
// Parameters: SCAN_DIV >= 2, BLANK_CYC < SCAN_DIV, BLINK_FRAMES >= 1.
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import clock_disp_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 50
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_driver_if.slave   bus
);

   localparam int SLOT_W = $clog2(SCAN_DIV);
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int IDX_W  = $clog2(NUM_DIGITS);

   logic [SLOT_W-1:0] slot_cnt;
   logic [IDX_W-1:0]  digit_idx;
   logic [FRM_W-1:0]  frame_cnt;
   logic              blink_phase;
   disp_snap_t        shadow;
   disp_snap_t        live;

   logic              slot_wrap;
   logic              snap_evt;

   assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
   assign snap_evt  = slot_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));

   assign live = '{
      fields:    {bus.field3, bus.field2, bus.field1, bus.field0},
      dp_mask:   bus.dp_mask,
      sel_field: bus.sel_field,
      set_mode:  bus.set_mode,
      lz_blank:  bus.lz_blank
   };

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else begin
         slot_cnt  <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
         if (slot_wrap) begin
            digit_idx <= digit_idx + IDX_W'(1);
         end
      end
   end

   // NOTE: the shadows are reset (not left uninitialised like a RAM) because
   // the first frame after reset is displayed from them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow      <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (snap_evt) begin
         shadow <= live;
         if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FRM_W'(1);
         end
      end
   end

   // Output decision for the current slot/digit; registered below.
   logic [3:0]            nibble;
   logic [6:0]            glyph_n;
   logic                  blank_digit;
   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [NUM_DIGITS-1:0] an_d;

   assign nibble = digit_nibble(shadow.fields, digit_idx);

   bcd_to_7seg u_dec (
      .nibble (nibble),
      .seg_n  (glyph_n)
   );

   always_comb begin
      blank_digit = 1'b0;
      // digit_idx[2:1] is the field that owns this digit.
      if (shadow.set_mode && (digit_idx[2:1] == shadow.sel_field) && blink_phase) begin
         blank_digit = 1'b1;
      end
      if (shadow.lz_blank && (digit_idx == IDX_W'(NUM_DIGITS - 1)) && (nibble == 4'd0)) begin
         blank_digit = 1'b1;
      end

      seg_d = blank_digit ? SEG_BLANK : glyph_n;
      dp_d  = blank_digit ? 1'b1 : ~shadow.dp_mask[digit_idx];

      if (slot_cnt < SLOT_W'(BLANK_CYC)) begin
         an_d = '1;
      end else begin
         an_d = ~(NUM_DIGITS'(1) << digit_idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg_n       <= SEG_BLANK;
         bus.dp_n        <= 1'b1;
         bus.an_n        <= '1;
         bus.frame_start <= 1'b0;
      end else begin
         bus.seg_n       <= seg_d;
         bus.dp_n        <= dp_d;
         bus.an_n        <= an_d;
         bus.frame_start <= snap_evt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=1,
// BLINK_FRAMES=2. The stimulus side predicts each cycle's outputs from the
// cycle number since reset release (slot, digit and frame by division) and
// the inputs seen at each frame boundary; a monitor compares after each edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int S     = 4;
   localparam int BC    = 1;
   localparam int BF    = 2;
   localparam int FRAME = 8 * S;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV     (S),
      .BLANK_CYC    (BC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [6:0] seg;
      logic       dp;
      logic [7:0] an;
      logic       fs;
   } out_t;

   out_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;

   // Reference model state: edges since release and the frame's latched inputs.
   int         n;
   logic [7:0] m_field[4];
   logic [7:0] m_dp;
   logic [1:0] m_sel;
   logic       m_set;
   logic       m_lz;

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Glyph from the list of lit segments; anything but 0..9 is a dash.
   function automatic logic [6:0] ref_glyph(int d);
      string      s;
      logic [6:0] g;
      g = 7'h7F;
      case (d)
         0:       s = "abcdef";
         1:       s = "bc";
         2:       s = "abdeg";
         3:       s = "abcdg";
         4:       s = "bcfg";
         5:       s = "acdfg";
         6:       s = "acdefg";
         7:       s = "abc";
         8:       s = "abcdefg";
         9:       s = "abcdfg";
         default: s = "g";
      endcase
      for (int k = 0; k < s.len(); k++) g[int'(s[k]) - 97] = 1'b0;
      return g;
   endfunction

   // Outputs visible after edge e reflect the counters during cycle e-1.
   function automatic out_t model_out(int e);
      out_t r;
      int   t, slot, idx, f, blink, nib;
      bit   blank;
      t     = e - 1;
      slot  = t % S;
      idx   = (t / S) % 8;
      f     = t / FRAME;
      blink = (f / BF) % 2;
      nib   = (m_field[idx / 2] >> (4 * (idx % 2))) & 8'h0F;
      blank = (m_set && (idx / 2 == int'(m_sel)) && blink == 1) ||
              (m_lz && idx == 7 && nib == 0);
      r.seg = blank ? 7'h7F : ref_glyph(nib);
      r.dp  = blank ? 1'b1 : ~m_dp[idx];
      r.an  = (slot < BC) ? 8'hFF : ~(8'h01 << idx);
      r.fs  = (e % FRAME == 0);
      return r;
   endfunction

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < 4; i++) m_field[i] = 8'h00;
      m_dp  = 8'h00;
      m_sel = 2'd0;
      m_set = 1'b0;
      m_lz  = 1'b0;
   endtask

   // Called at a falling edge with inputs already set for the coming edge.
   task automatic step();
      n++;
      exp_q.push_back(model_out(n));
      if (n % FRAME == 0) begin
         m_field[0] = bus.field0;
         m_field[1] = bus.field1;
         m_field[2] = bus.field2;
         m_field[3] = bus.field3;
         m_dp  = bus.dp_mask;
         m_sel = bus.sel_field;
         m_set = bus.set_mode;
         m_lz  = bus.lz_blank;
      end
      @(negedge clk);
   endtask

   task automatic run(int cycles, bit rnd);
      for (int c = 0; c < cycles; c++) begin
         if (rnd && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 5))
               0: bus.field0 = 8'($urandom);
               1: bus.field1 = 8'($urandom);
               2: bus.field2 = 8'($urandom);
               3: bus.field3 = 8'($urandom) & 8'h1F;
               4: begin
                  bus.set_mode  = 1'($urandom);
                  bus.sel_field = 2'($urandom);
               end
               default: begin
                  bus.lz_blank = 1'($urandom);
                  bus.dp_mask  = 8'($urandom);
               end
            endcase
         end
         step();
      end
   endtask

   // Monitor: one comparison per clock while the scoreboard is active.
   always @(posedge clk) begin
      out_t e;
      #1;
      if (mon_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got no expected entry at t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (bus.seg_n !== e.seg || bus.dp_n !== e.dp || bus.an_n !== e.an ||
                bus.frame_start !== e.fs) begin
               bad++;
               $display("FAIL out_edge%0d: got seg=%h dp=%b an=%h fs=%b expected seg=%h dp=%b an=%h fs=%b",
                        n, bus.seg_n, bus.dp_n, bus.an_n, bus.frame_start,
                        e.seg, e.dp, e.an, e.fs);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.field3    = 8'h23;
      bus.field2    = 8'h59;
      bus.field1    = 8'h58;
      bus.field0    = 8'h07;
      bus.set_mode  = 1'b0;
      bus.sel_field = 2'd0;
      bus.lz_blank  = 1'b0;
      bus.dp_mask   = 8'h00;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_seg_n", 32'(bus.seg_n), 32'h7F);
      check("reset_dp_n", 32'(bus.dp_n), 32'h1);
      check("reset_an_n", 32'(bus.an_n), 32'hFF);
      check("reset_frame_start", 32'(bus.frame_start), 32'h0);

      rst_n  = 1'b1;
      mon_en = 1'b1;

      // First frame from zeroed shadows, then 23:59:58:07.
      run(FRAME + 10, 1'b0);
      // Mid-frame change must wait for the next snapshot.
      bus.field0 = 8'h08;
      run(2 * FRAME - 10, 1'b0);
      // Blink field 1 (digits 3:2).
      bus.set_mode  = 1'b1;
      bus.sel_field = 2'd1;
      run(6 * FRAME, 1'b0);
      bus.set_mode = 1'b0;
      // Non-decimal nibble shows a dash.
      bus.field2 = 8'h3C;
      run(2 * FRAME, 1'b0);
      // Leading-zero blanking of digit 7 only.
      bus.lz_blank = 1'b1;
      bus.field3   = 8'h09;
      run(2 * FRAME, 1'b0);
      bus.field3 = 8'h10;
      run(2 * FRAME, 1'b0);
      bus.dp_mask = 8'hA5;
      run(2 * FRAME, 1'b0);
      // Randomised traffic.
      run(30 * FRAME, 1'b1);

      // Asynchronous reset while digit 5 is being scanned.
      for (int c = 0; c < FRAME; c++) begin
         if ((n / S) % 8 == 5 && n % S == 0) break;
         run(1, 1'b1);
      end
      mon_en = 1'b0;
      check("pre_reset_an_n_lit", 32'(bus.an_n == 8'hFF), 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_an_n", 32'(bus.an_n), 32'hFF);
      check("async_reset_seg_n", 32'(bus.seg_n), 32'h7F);
      check("async_reset_dp_n", 32'(bus.dp_n), 32'h1);
      check("async_reset_frame_start", 32'(bus.frame_start), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      exp_q.delete();
      mon_en = 1'b1;
      run(3 * FRAME, 1'b1);
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
